// File: rtl/vsq_quant_ctrl.sv
// vsq_quant_ctrl: sequences ReLU rows into the 64-entry VSQ buffer, zero-pads
// partial tiles on flush, waits for the output RAM, then runs the 64-cycle
// quantize pass while holding off the upstream stream.
module vsq_quant_ctrl #(
    parameter int LANES = 16,
    parameter int DW    = 40,
    parameter int ROWS  = 64,
    parameter int AW    = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [LANES*DW-1:0] i_row,
    input  logic                i_flush,
    input  logic                i_ram_free,
    output logic                o_buf_we,
    output logic [AW-1:0]       o_buf_waddr,
    output logic [LANES*DW-1:0] o_buf_wdata,
    output logic [LANES*DW-1:0] o_q_data,
    output logic                o_q_start,
    output logic                o_busy,
    output logic                o_tile_done,
    output logic [15:0]         o_tile_cnt
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PAD   = 2'd1,
        S_WAIT  = 2'd2,
        S_QUANT = 2'd3
    } state_t;

    // Last row index; ROWS is a power of two so pointers wrap to 0 naturally.
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW-1:0] qcnt_reg, qcnt_next;
    logic [15:0]   tile_cnt_reg, tile_cnt_next;

    // High on a cycle where the upstream row is taken; selects i_row onto
    // both the buffer write data and the running-max input.
    logic          accept;

    // State register and counters; async reset aborts any tile in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_FILL;
            wptr_reg     <= '0;
            qcnt_reg     <= '0;
            tile_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wptr_reg     <= wptr_next;
            qcnt_reg     <= qcnt_next;
            tile_cnt_reg <= tile_cnt_next;
        end
    end

    // Next-state and control outputs; a same-cycle accept is written before
    // a flush is considered, so a flush on row 63 just completes the tile.
    always_comb begin
        state_next    = state_reg;
        wptr_next     = wptr_reg;
        qcnt_next     = qcnt_reg;
        tile_cnt_next = tile_cnt_reg;
        o_ready       = 1'b0;
        o_buf_we      = 1'b0;
        o_q_start     = 1'b0;
        o_tile_done   = 1'b0;
        accept        = 1'b0;

        case (state_reg)
            S_FILL: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept    = 1'b1;
                    o_buf_we  = 1'b1;
                    wptr_next = wptr_reg + 1'b1;
                    if (wptr_reg == LAST_ROW) begin
                        state_next = S_WAIT;
                    end else if (i_flush) begin
                        state_next = S_PAD;
                    end
                end else if (i_flush && (wptr_reg != '0)) begin
                    state_next = S_PAD;
                end
            end

            S_PAD: begin
                o_buf_we  = 1'b1;
                wptr_next = wptr_reg + 1'b1;
                if (wptr_reg == LAST_ROW) begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_ram_free) begin
                    o_q_start  = 1'b1;
                    qcnt_next  = '0;
                    state_next = S_QUANT;
                end
            end

            S_QUANT: begin
                qcnt_next = qcnt_reg + 1'b1;
                if (qcnt_reg == LAST_ROW) begin
                    o_tile_done   = 1'b1;
                    tile_cnt_next = tile_cnt_reg + 16'd1;
                    state_next    = S_FILL;
                end
            end

            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    assign o_buf_waddr = wptr_reg;
    assign o_busy      = (state_reg != S_FILL);
    assign o_tile_cnt  = tile_cnt_reg;

    // Per-lane data steering: the accepted row, or zero for pad rows and idle
    // cycles (zero never raises a running max).
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign o_buf_wdata[gi*DW +: DW] = accept ? i_row[gi*DW +: DW] : '0;
            assign o_q_data[gi*DW +: DW]    = accept ? i_row[gi*DW +: DW] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_vsq_quant_ctrl.sv
// Directed bench for vsq_quant_ctrl: full tiles, flush padding, RAM-busy
// stall, streaming back-to-back tiles, flush corner cases, async reset abort.
module tb_vsq_quant_ctrl;

    localparam int LANES = 16;
    localparam int DW    = 40;
    localparam int RW    = LANES * DW;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [RW-1:0] i_row = '0;
    logic          i_flush = 1'b0;
    logic          i_ram_free = 1'b0;
    logic          o_buf_we;
    logic [5:0]    o_buf_waddr;
    logic [RW-1:0] o_buf_wdata;
    logic [RW-1:0] o_q_data;
    logic          o_q_start;
    logic          o_busy;
    logic          o_tile_done;
    logic [15:0]   o_tile_cnt;

    vsq_quant_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_row       (i_row),
        .i_flush     (i_flush),
        .i_ram_free  (i_ram_free),
        .o_buf_we    (o_buf_we),
        .o_buf_waddr (o_buf_waddr),
        .o_buf_wdata (o_buf_wdata),
        .o_q_data    (o_q_data),
        .o_q_start   (o_q_start),
        .o_busy      (o_busy),
        .o_tile_done (o_tile_done),
        .o_tile_cnt  (o_tile_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Event log, written only by the negedge monitor.
    int            wr_cnt = 0;
    int            wa_q[$];
    logic [RW-1:0] wd_q[$];
    int            acc_q[$];
    int            start_cnt = 0;
    int            start_cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            q_bad = 0;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_buf_we) begin
                wr_cnt <= wr_cnt + 1;
                wa_q.push_back(int'(o_buf_waddr));
                wd_q.push_back(o_buf_wdata);
            end
            if (i_valid && o_ready) begin
                acc_q.push_back(cyc);
                if (o_q_data != i_row) q_bad <= q_bad + 1;
            end else if (o_q_data != '0) begin
                q_bad <= q_bad + 1;
            end
            if (o_q_start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end
            if (o_tile_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mkrow(input int k);
        logic [RW-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[l*DW +: DW] = 40'(k * 64 + l + 1) | (l[0] ? 40'h80_0000_0000 : 40'h0);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_row   = '0;
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic send_rows(input int first, input int n, input logic flush_last);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_row   = mkrow(first + i);
            i_flush = flush_last && (i == n - 1);
            tick();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_row   = '0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_cnt >= target), 64'd1);
    endtask

    // Returns mismatch counts of a 64-row tile log starting at base: address
    // must be 0..63, data mkrow(first+i) for i<nrows and zero afterwards.
    task automatic tile_log(input int base, input int first, input int nrows,
                            output int bad_a, output int bad_d);
        bad_a = 0;
        bad_d = 0;
        for (int i = 0; i < 64; i++) begin
            if (base + i >= wa_q.size()) begin
                bad_a++;
                bad_d++;
            end else begin
                if (wa_q[base + i] != i) bad_a++;
                if (wd_q[base + i] != ((i < nrows) ? mkrow(first + i) : '0)) bad_d++;
            end
        end
    endtask

    initial begin
        int bw, bs, bd, ba, bad_a, bad_d, n, rise, k, ready_hi;
        logic acc;

        // Reset state
        i_rst_n = 1'b0;
        #3;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_we", 64'(o_buf_we), 64'd0);
        chk("rst_start", 64'(o_q_start), 64'd0);
        chk("rst_done", 64'(o_tile_done), 64'd0);
        chk("rst_tcnt", 64'(o_tile_cnt), 64'd0);
        chk("rst_waddr", 64'(o_buf_waddr), 64'd0);
        do_reset();

        // T1: 64 rows back-to-back with the RAM free
        i_ram_free = 1'b1;
        bw = wr_cnt; bs = start_cnt; bd = done_cnt;
        send_rows(0, 64, 1'b0);
        wait_done(bd + 1, "t1_done_seen");
        tile_log(bw, 0, 64, bad_a, bad_d);
        chk("t1_wr_cnt", 64'(wr_cnt - bw), 64'd64);
        chk("t1_addr_seq", 64'(bad_a), 64'd0);
        chk("t1_data_seq", 64'(bad_d), 64'd0);
        chk("t1_start_lat", 64'(start_cyc - acc_q[acc_q.size() - 1]), 64'd1);
        chk("t1_done_lat", 64'(done_cyc - start_cyc), 64'd64);
        chk("t1_start_cnt", 64'(start_cnt - bs), 64'd1);
        chk("t1_tile_cnt", 64'(o_tile_cnt), 64'd1);
        chk("t1_ready_after", 64'(o_ready), 64'd1);
        chk("t1_busy_after", 64'(o_busy), 64'd0);

        // T2: 10 rows then flush -> 54 zero pad rows
        do_reset();
        bw = wr_cnt; bd = done_cnt;
        send_rows(100, 10, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("t2_pad_ready", 64'(o_ready), 64'd0);
        chk("t2_pad_busy", 64'(o_busy), 64'd1);
        wait_done(bd + 1, "t2_done_seen");
        tile_log(bw, 100, 10, bad_a, bad_d);
        chk("t2_wr_cnt", 64'(wr_cnt - bw), 64'd64);
        chk("t2_addr_seq", 64'(bad_a), 64'd0);
        chk("t2_data_pad", 64'(bad_d), 64'd0);
        chk("t2_tile_cnt", 64'(o_tile_cnt), 64'd1);

        // T3: RAM busy for 20 cycles after a full tile
        do_reset();
        i_ram_free = 1'b0;
        bs = start_cnt; bd = done_cnt;
        send_rows(200, 64, 1'b0);
        ready_hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_ready) ready_hi++;
            tick();
        end
        chk("t3_ready_low", 64'(ready_hi), 64'd0);
        chk("t3_no_start", 64'(start_cnt - bs), 64'd0);
        i_ram_free = 1'b1;
        rise = cyc;
        wait_done(bd + 1, "t3_done_seen");
        chk("t3_start_cyc", 64'(start_cyc - rise), 64'd0);
        chk("t3_done_lat", 64'(done_cyc - start_cyc), 64'd64);

        // T4: i_valid held high across 3 tiles
        do_reset();
        bw = wr_cnt; bs = start_cnt; bd = done_cnt; ba = acc_q.size();
        k = 0;
        n = 0;
        i_valid = 1'b1;
        while (done_cnt < bd + 3 && n < 1000) begin
            i_row = mkrow(1000 + k);
            acc = o_ready;
            tick();
            if (acc) k++;
            n++;
        end
        i_valid = 1'b0;
        i_row = '0;
        chk("t4_finished", 64'(done_cnt - bd), 64'd3);
        chk("t4_wr_cnt", 64'(wr_cnt - bw), 64'd192);
        chk("t4_acc_cnt", 64'(acc_q.size() - ba), 64'd192);
        bad_a = 0;
        bad_d = 0;
        for (int t = 0; t < 3; t++) begin
            int ta, td;
            tile_log(bw + t * 64, 1000 + t * 64, 64, ta, td);
            bad_a += ta;
            bad_d += td;
        end
        chk("t4_addr_seq", 64'(bad_a), 64'd0);
        chk("t4_data_seq", 64'(bad_d), 64'd0);
        chk("t4_span", 64'(done_cyc - acc_q[ba]), 64'd386);
        chk("t4_tile_cnt", 64'(o_tile_cnt), 64'd3);

        // T5: flush with nothing held, then flush on the row-63 accept
        do_reset();
        bw = wr_cnt; bd = done_cnt;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("t5_empty_ready", 64'(o_ready), 64'd1);
        chk("t5_empty_busy", 64'(o_busy), 64'd0);
        chk("t5_empty_wr", 64'(wr_cnt - bw), 64'd0);
        send_rows(300, 64, 1'b1);
        wait_done(bd + 1, "t5_done_seen");
        tile_log(bw, 300, 64, bad_a, bad_d);
        chk("t5_wr_cnt", 64'(wr_cnt - bw), 64'd64);
        chk("t5_data_seq", 64'(bad_d), 64'd0);
        chk("t5_start_lat", 64'(start_cyc - acc_q[acc_q.size() - 1]), 64'd1);
        chk("t5_tile_cnt", 64'(o_tile_cnt), 64'd1);

        // T6: async reset at qcnt=30, then a clean tile from address 0
        bs = start_cnt;
        send_rows(400, 64, 1'b0);
        n = 0;
        while (start_cnt == bs && n < 200) begin
            tick();
            n++;
        end
        chk("t6_start_seen", 64'(start_cnt - bs), 64'd1);
        for (int i = 0; i < 30; i++) tick();
        chk("t6_mid_busy", 64'(o_busy), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(o_ready), 64'd1);
        chk("t6_rst_busy", 64'(o_busy), 64'd0);
        chk("t6_rst_tcnt", 64'(o_tile_cnt), 64'd0);
        chk("t6_rst_done", 64'(o_tile_done), 64'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        bw = wr_cnt; bd = done_cnt;
        send_rows(500, 64, 1'b0);
        wait_done(bd + 1, "t6_done_seen");
        tile_log(bw, 500, 64, bad_a, bad_d);
        chk("t6_addr_seq", 64'(bad_a), 64'd0);
        chk("t6_data_seq", 64'(bad_d), 64'd0);
        chk("t6_tile_cnt", 64'(o_tile_cnt), 64'd1);

        // Running-max input mirrored only on accepts, zero otherwise
        chk("q_data_mirror", 64'(q_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
